// File: rtl/lc3b_fetch_if.sv
// Instruction-cache line-read handshake between the fetch stage and the cache.
interface lc3b_fetch_if;
  logic         icache_read;
  logic [15:0]  icache_addr;
  logic         icache_resp;
  logic [127:0] icache_rdata;

  modport master (
    output icache_read,
    output icache_addr,
    input  icache_resp,
    input  icache_rdata
  );

  modport slave (
    input  icache_read,
    input  icache_addr,
    output icache_resp,
    output icache_rdata
  );
endinterface

// File: rtl/lc3b_fetch.sv
// LC-3b fetch stage with a single-line instruction buffer in front of the I-cache.
// Macro FETCH_LINEBUF_EN keeps the line across instructions; undefined, each issue drops it.
module lc3b_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  lc3b_fetch_if.master       icache,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  input  logic               stall,
  output logic               if_valid,
  output logic [15:0]        if_instr,
  output logic [15:0]        if_pc,
  output logic [15:0]        if_pc_plus2
);

  typedef enum logic [0:0] {StRun, StMiss} state_e;

  state_e        r_state, w_state_nxt;
  logic [15:0]   r_pc, w_pc_nxt;
  logic [127:0]  r_buf_data, w_buf_data_nxt;
  logic [11:0]   r_buf_tag, w_buf_tag_nxt;
  logic          r_buf_valid, w_buf_valid_nxt;
  logic [11:0]   r_miss_tag, w_miss_tag_nxt;
  logic          r_if_valid, w_if_valid_nxt;
  logic [15:0]   r_if_instr, w_if_instr_nxt;
  logic [15:0]   r_if_pc, w_if_pc_nxt;
  logic [15:0]   r_if_pc_plus2, w_if_pc_plus2_nxt;

  logic          w_hit;
  logic [15:0]   w_word;

  assign w_hit  = r_buf_valid && (r_buf_tag == r_pc[15:4]);
  assign w_word = r_buf_data[{r_pc[3:1], 4'b0000} +: 16];

  // The miss line is latched separately so a redirect during MISS cannot move the address.
  assign icache.icache_read = rst_n && (r_state == StMiss);
  assign icache.icache_addr = {r_miss_tag, 4'h0};

  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus2 = r_if_pc_plus2;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_buf_data_nxt    = r_buf_data;
    w_buf_tag_nxt     = r_buf_tag;
    w_buf_valid_nxt   = r_buf_valid;
    w_miss_tag_nxt    = r_miss_tag;
    w_if_valid_nxt    = r_if_valid;
    w_if_instr_nxt    = r_if_instr;
    w_if_pc_nxt       = r_if_pc;
    w_if_pc_plus2_nxt = r_if_pc_plus2;

    // The fill completes regardless of stall or redirect.
    if (r_state == StMiss && icache.icache_resp) begin
      w_buf_data_nxt  = icache.icache_rdata;
      w_buf_tag_nxt   = r_miss_tag;
      w_buf_valid_nxt = 1'b1;
      w_state_nxt     = StRun;
    end

    if (redirect) begin
      w_if_valid_nxt = 1'b0;
      w_pc_nxt       = {redirect_pc[15:1], 1'b0};
    end else if (!stall) begin
      if (r_state == StRun) begin
        if (w_hit) begin
          w_if_valid_nxt    = 1'b1;
          w_if_instr_nxt    = w_word;
          w_if_pc_nxt       = r_pc;
          w_if_pc_plus2_nxt = r_pc + 16'd2;
          w_pc_nxt          = r_pc + 16'd2;
`ifdef FETCH_LINEBUF_EN
          w_buf_valid_nxt   = r_buf_valid;
`else
          w_buf_valid_nxt   = 1'b0;
`endif
        end else begin
          w_if_valid_nxt = 1'b0;
          w_miss_tag_nxt = r_pc[15:4];
          w_state_nxt    = StMiss;
        end
      end else begin
        w_if_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_pc          <= {RESET_PC[15:1], 1'b0};
      r_buf_valid   <= 1'b0;
      r_buf_tag     <= 12'h000;
      r_miss_tag    <= 12'h000;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 16'h0000;
      r_if_pc       <= 16'h0000;
      r_if_pc_plus2 <= 16'h0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_buf_valid   <= w_buf_valid_nxt;
      r_buf_tag     <= w_buf_tag_nxt;
      r_miss_tag    <= w_miss_tag_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_instr    <= w_if_instr_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_if_pc_plus2 <= w_if_pc_plus2_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_buf_data <= w_buf_data_nxt;
  end

endmodule

// File: tb/tb_lc3b_fetch.sv
// Directed bench for lc3b_fetch: per-cycle vector table plus a straight-line run
// against an auto-responding cache. Expectations follow the FETCH_LINEBUF_EN build.
module tb_lc3b_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;

  lc3b_fetch_if u_if ();

  lc3b_fetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .icache      (u_if),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2)
  );

  always #5 clk = ~clk;

  // Memory image: the word at byte address a is 16'h1000 + a/2.
  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  always_comb begin
    u_if.icache_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      u_if.icache_rdata[16*i +: 16] = instr_of({u_if.icache_addr[15:4], i[2:0], 1'b0});
    end
  end

  typedef struct {
    logic        rn;
    logic        rd;
    logic [15:0] rpc;
    logic        st;
    logic        rs;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_p2;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] o_pc, o_instr, o_p2;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic out_set(input logic [15:0] pc);
    o_pc = pc; o_instr = instr_of(pc); o_p2 = pc + 16'd2;
  endtask

  task automatic out_clr();
    o_pc = 16'h0; o_instr = 16'h0; o_p2 = 16'h0;
  endtask

  task automatic add(input logic rn, input logic rd, input logic [15:0] rpc, input logic st,
                     input logic rs, input logic er, input logic [15:0] ea, input logic ev);
    vec_t v;
    v.rn = rn; v.rd = rd; v.rpc = rpc; v.st = st; v.rs = rs;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev;
    v.e_pc = o_pc; v.e_instr = o_instr; v.e_p2 = o_p2;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic build_table();
    out_clr();
    add(0, 0, 16'h0, 0, 0, 0, 16'h0000, 0);   // reset
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);   // cold miss on line 0
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);   // fill
`ifdef FETCH_LINEBUF_EN
    for (int i = 0; i < 8; i++) begin
      out_set(16'(2 * i));
      add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    end
    add(1, 0, 16'h0, 0, 0, 1, 16'h0010, 0);   // next line misses
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h0010); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 16'h0, 1, 0, 0, 16'h0000, 1);
    out_set(16'h0012); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 1, 16'h0020, 0, 0, 0, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0020, 0);
    add(1, 1, 16'h3006, 0, 0, 1, 16'h0020, 0); // redirect while missing
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 0, 1, 16'h3000, 0);
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h3006); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 1, 16'hFFFE, 0, 0, 0, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 0, 1, 16'hFFF0, 0);
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'hFFFE); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);   // wrapped pc misses line 0
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h0000); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
`else
    out_set(16'h0000); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);   // buffer dropped on issue
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h0002); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h0004); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 16'h0, 1, 0, 0, 16'h0000, 1);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);
    add(1, 0, 16'h0, 1, 1, 0, 16'h0000, 0);   // stalled fill still completes
    out_set(16'h0006); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);
    add(1, 1, 16'h3007, 0, 0, 1, 16'h0000, 0); // redirect in MISS, bit 0 dropped
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 0, 1, 16'h3000, 0);
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h3006); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 1, 16'hFFFE, 0, 0, 0, 16'h0000, 0);
    add(1, 0, 16'h0, 0, 0, 1, 16'hFFF0, 0);
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'hFFFE); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
    add(1, 0, 16'h0, 0, 0, 1, 16'h0000, 0);
    add(1, 1, 16'h0040, 0, 1, 0, 16'h0000, 0); // redirect with resp
    add(1, 0, 16'h0, 0, 0, 1, 16'h0040, 0);
    out_clr();
    add(0, 0, 16'h0, 0, 0, 0, 16'h0000, 0);   // reset mid-MISS
    add(1, 0, 16'h0, 0, 1, 1, 16'h0000, 0);   // late resp ignored
    add(1, 0, 16'h0, 0, 1, 0, 16'h0000, 0);
    out_set(16'h0000); add(1, 0, 16'h0, 0, 0, 0, 16'h0000, 1);
`endif
  endtask

  initial begin
    int issued, reads, last_c, gap;
    logic [15:0] exp_pc;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; stall = 1'b0;
    u_if.icache_resp = 1'b0;
    build_table();

    foreach (tbl[r]) begin
      @(negedge clk);
      rst_n = tbl[r].rn; redirect = tbl[r].rd; redirect_pc = tbl[r].rpc;
      stall = tbl[r].st; u_if.icache_resp = tbl[r].rs;
      @(posedge clk); #1;
      chk("icache_read", r, {15'h0, u_if.icache_read}, {15'h0, tbl[r].e_read});
      if (tbl[r].e_read) chk("icache_addr", r, u_if.icache_addr, tbl[r].e_addr);
      chk("if_valid", r, {15'h0, if_valid}, {15'h0, tbl[r].e_valid});
      chk("if_pc", r, if_pc, tbl[r].e_pc);
      chk("if_instr", r, if_instr, tbl[r].e_instr);
      chk("if_pc_plus2", r, if_pc_plus2, tbl[r].e_p2);
    end

    // Straight-line run against a cache answering on the first MISS cycle.
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; u_if.icache_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issued = 0; reads = 0; last_c = -1; exp_pc = 16'h0000;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      u_if.icache_resp = u_if.icache_read;
      if (u_if.icache_read) reads++;
      @(posedge clk); #1;
      if (if_valid) begin
        chk("run_pc", c, if_pc, exp_pc);
        chk("run_instr", c, if_instr, instr_of(exp_pc));
`ifndef FETCH_LINEBUF_EN
        if (last_c >= 0) begin
          gap = c - last_c;
          chk("run_gap", c, 16'(gap), 16'd3);
        end
`endif
        last_c = c;
        exp_pc = exp_pc + 16'd2;
        issued++;
      end
    end
    chk("run_progress", 0, {15'h0, issued >= 6}, 16'h1);
`ifdef FETCH_LINEBUF_EN
    chk("run_reads", 0, {15'h0, (reads == (issued + 7) / 8) || (reads == (issued + 7) / 8 + 1)},
        16'h1);
`else
    chk("run_reads", 0, {15'h0, (reads == issued) || (reads == issued + 1)}, 16'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_fetch.md
LC3B_FETCH -- requirements
Module: lc3b_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 icache_read  out  1  line read request.
REQ-006 icache_addr  out  16  line-aligned address, low 4 bits zero.
REQ-007 icache_resp  in  1  one-cycle completion pulse for the current read.
REQ-008 icache_rdata  in  128  returned line; word i occupies bits [16i+15:16i].
REQ-009 redirect  in  1  flush and load a new PC (branch, jump or trap target).
REQ-010 redirect_pc  in  16  new PC, sampled when redirect=1.
REQ-011 stall  in  1  decode not ready; hold outputs.
REQ-012 if_valid  out  1  if_instr/if_pc/if_pc_plus2 carry a real instruction.
REQ-013 if_instr  out  16  fetched instruction word.
REQ-014 if_pc  out  16  address of if_instr.
REQ-015 if_pc_plus2  out  16  if_pc+2, modulo 2^16.

Function
REQ-016 State: pc[15:0]; line buffer (128-bit data, 12-bit tag, valid bit); FSM {RUN, MISS}; registered outputs.
REQ-017 Hit means buf_valid=1 and tag==pc[15:4].
REQ-018 RUN with a hit, stall=0 and redirect=0: at the next edge, if_instr gets buffer word pc[3:1], if_pc gets pc, if_valid gets 1, and pc gets pc+2; the hit-to-output latency is 1 cycle.
REQ-019 RUN with a miss, stall=0 and redirect=0: if_valid gets 0, the FSM goes to MISS, and pc holds.
REQ-020 MISS: icache_read=1 and icache_addr={pc[15:4],4'h0}, both held stable until icache_resp; icache_read=0 in RUN.
REQ-021 MISS with icache_resp=1: data gets icache_rdata, tag gets pc[15:4], buf_valid gets 1, and the FSM goes to RUN; the line is usable on the next cycle.
REQ-022 Miss cost: resp at cycle k gives a hit in RUN at k+1 and if_valid=1 at k+2.
REQ-023 stall=1 with redirect=0: outputs and pc hold; in MISS, the cache handshake still completes and the buffer fills.
REQ-024 redirect=1 has priority over stall: if_valid gets 0 and pc gets redirect_pc at the next edge.
REQ-025 Redirect in RUN: the FSM stays in RUN and the buffer is kept.
REQ-026 Redirect in MISS: the outstanding read is not abandoned.
  - icache_addr stays at the old line until resp.
  - The returned line is written to the buffer.
  - The FSM then returns to RUN and evaluates a hit/miss against the new pc.
REQ-027 Redirect in the same cycle as icache_resp: the buffer fills from the response and pc gets redirect_pc.
REQ-028 PC wrap: pc 16'hFFFE advances to 16'h0000; if_pc_plus2 at if_pc=16'hFFFE is 16'h0000.
REQ-029 redirect_pc bit 0 is ignored; pc[0] is always 0.
REQ-030 When the FSM is in MISS and stall=0, if_valid is 0 every cycle (bubble).

Reset
REQ-031 While rst_n=0 at an edge, the following are loaded:
  - pc = RESET_PC with bit 0 cleared;
  - FSM = RUN and buf_valid = 0;
  - if_valid = 0, if_instr = 16'h0000, if_pc = 16'h0000, if_pc_plus2 = 16'h0000.
REQ-032 Outputs during reset: icache_read=0.
REQ-033 Reset mid-MISS abandons the read; a late icache_resp arriving in RUN is ignored.

Configuration
REQ-034 Macro FETCH_LINEBUF_EN.
  - Defined: the buffer is retained across instructions as specified above.
  - Undefined: buf_valid is cleared whenever an instruction is issued (REQ-018), so every instruction needs its own cache read; all other behaviour is identical.

Verification
REQ-035 Reset with RESET_PC=16'h0000, then resp two cycles after the request with line words 0..7 = 16'h1000..16'h1007 -> icache_addr=16'h0000, then if_valid with instructions 16'h1000..16'h1007 on 8 consecutive cycles (macro defined), if_pc 16'h0000..16'h000E.
REQ-036 pc=16'h000E issued -> next fetch misses on 16'h0010 -> one read of line 16'h0010, with bubbles until fill.
REQ-037 stall=1 for 3 cycles on a valid output -> if_instr/if_pc unchanged, with no duplicate or skipped instruction afterwards.
REQ-038 redirect to 16'h3006 during MISS for line 16'h0020 -> read stays at 16'h0020 until resp, then a new read at 16'h3000, first valid output with if_pc=16'h3006 (word 3).
REQ-039 redirect to 16'hFFFE with a hit -> if_pc=16'hFFFE with if_pc_plus2=16'h0000, then a miss to line 16'h0000.
REQ-040 Macro undefined, straight-line code -> one icache_read per instruction; if_valid at most once every 3 cycles with a 1-cycle resp.
